// File: rtl/acc_carry_unit.sv
// Accumulator/carry writeback stage: latches ALU results into ACC/CY, sequences XCH and index-register writes.
// Latency: ACC/CY and register strobe update one cycle after accept; XCH delivers the new ACC two cycles after accept.
// Backpressure: o_wb_ready drops for the single SWAP cycle of an exchange; the producer holds its command meanwhile.
module acc_carry_unit #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH:0]   i_alu_result,
  input  logic [2:0]       i_wb_op,
  input  logic             i_wb_valid,
  output logic             o_wb_ready,
  input  logic [WIDTH-1:0] i_regval,
  output logic             o_reg_wr_en,
  output logic [WIDTH-1:0] o_reg_wr_data,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_carry,
  output logic             o_acc_zero
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WR_AC = 3'd1;
  localparam logic [2:0] OP_WR_A  = 3'd2;
  localparam logic [2:0] OP_WR_C  = 3'd3;
  localparam logic [2:0] OP_XCH   = 3'd4;
  localparam logic [2:0] OP_WR_R  = 3'd5;
  localparam logic [2:0] OP_CLR   = 3'd6;

  typedef enum logic {ST_IDLE, ST_SWAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic             r_carry, w_carry_nxt;
  logic [WIDTH-1:0] r_temp, w_temp_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_sum    = i_alu_result[WIDTH-1:0];
  assign w_cout   = i_alu_result[WIDTH];
  assign w_accept = i_wb_valid && (r_state == ST_IDLE);

  // Next-state and next-register values; everything holds unless a command or the SWAP phase says otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_carry_nxt   = r_carry;
    w_temp_nxt    = r_temp;
    w_wr_en_nxt   = 1'b0;
    w_wr_data_nxt = r_wr_data;
    case (r_state)
      ST_SWAP: begin
        // Second half of the exchange: the captured register value lands in ACC.
        w_acc_nxt   = r_temp;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        if (w_accept) begin
          case (i_wb_op)
            OP_WR_AC: begin
              w_acc_nxt   = w_sum;
              w_carry_nxt = w_cout;
            end
            OP_WR_A:  w_acc_nxt   = w_sum;
            OP_WR_C:  w_carry_nxt = w_cout;
            OP_XCH: begin
              w_temp_nxt    = i_regval;
              w_wr_data_nxt = r_acc;
              w_wr_en_nxt   = 1'b1;
              w_state_nxt   = ST_SWAP;
            end
            OP_WR_R: begin
              w_wr_data_nxt = w_sum;
              w_wr_en_nxt   = 1'b1;
            end
            OP_CLR: begin
              w_acc_nxt   = '0;
              w_carry_nxt = 1'b0;
            end
            default: ;  // NOP and reserved opcode 7
          endcase
        end
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight exchange without a register write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_temp    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_carry   <= w_carry_nxt;
      r_temp    <= w_temp_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign o_wb_ready    = (r_state == ST_IDLE);
  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_wr_data = r_wr_data;
  assign o_acc         = r_acc;
  assign o_carry       = r_carry;
  assign o_acc_zero    = (r_acc == '0);

endmodule
